dm_port_arbiter: RTL and testbench

//  Shares one single-ported, synchronous-read RAM (1-cycle read latency) between

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/dm_resp_hold.sv | 33 +++
 rtl/dm_port_arbiter.sv | 115 +++++++++++
 tb/tb_dm_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared widths and response-owner encoding for the data-memory port arbiter.
package cpu_mem_pkg;

    localparam int unsigned DM_AW = 32;
    localparam int unsigned DM_DW = 32;
    localparam int unsigned DM_BE = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

endpackage

// File: rtl/dm_resp_hold.sv
// Read-response holder: passes fresh RAM data through on a response cycle and
// keeps it stable afterwards until the next response for the same requester.
module dm_resp_hold
    import cpu_mem_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [DM_DW-1:0] din,
    output logic [DM_DW-1:0] dout
);

    logic [DM_DW-1:0] hold_q;
    logic [DM_DW-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (valid) begin
            hold_d = din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign dout = valid ? din : hold_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates one single-ported synchronous RAM between IF and MEM. MEM has priority,
// but after STREAK_MAX MEM grants while IF waits, IF gets one grant.
module dm_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             if_req,
    input  logic [DM_AW-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DM_DW-1:0] if_rdata,

    input  logic             mem_req,
    input  logic [DM_BE-1:0] mem_wen,
    input  logic [DM_AW-1:0] mem_addr,
    input  logic [DM_DW-1:0] mem_wdata,
    output logic             mem_gnt,
    output logic             mem_rvalid,
    output logic [DM_DW-1:0] mem_rdata,

    output logic             ram_en,
    output logic [DM_BE-1:0] ram_wen,
    output logic [DM_AW-1:0] ram_addr,
    output logic [DM_DW-1:0] ram_wdata,
    input  logic [DM_DW-1:0] ram_rdata
);

    localparam int unsigned SW = $clog2(STREAK_MAX + 1);

    logic [SW-1:0] streak_q, streak_d;
    owner_e        owner_q, owner_d;

    logic if_req_v;
    logic mem_req_v;
    logic streak_full;

    // Requests are masked while in reset so every output reads as zero.
    assign if_req_v    = if_req & resetn;
    assign mem_req_v   = mem_req & resetn;
    assign streak_full = (streak_q == SW'(STREAK_MAX));

    assign mem_gnt = mem_req_v & ~(if_req_v & streak_full);
    assign if_gnt  = if_req_v & ~mem_gnt;

    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (mem_gnt) begin
            ram_en    = 1'b1;
            ram_wen   = mem_wen;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
        end else if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (mem_gnt && if_req_v) begin
            if (!streak_full) begin
                streak_d = streak_q + SW'(1);
            end
        end else if (if_gnt || !if_req_v) begin
            streak_d = '0;
        end
    end

    // Owner remembers who gets the RAM output next cycle; writes produce no response.
    always_comb begin
        owner_d = OWN_NONE;
        if (mem_gnt && (mem_wen == '0)) begin
            owner_d = OWN_MEM;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    assign if_rvalid  = (owner_q == OWN_IF);
    assign mem_rvalid = (owner_q == OWN_MEM);

    dm_resp_hold u_if_hold (
        .clk    (clk),
        .resetn (resetn),
        .valid  (if_rvalid),
        .din    (ram_rdata),
        .dout   (if_rdata)
    );

    dm_resp_hold u_mem_hold (
        .clk    (clk),
        .resetn (resetn),
        .valid  (mem_rvalid),
        .din    (ram_rdata),
        .dout   (mem_rdata)
    );

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: behavioural RAM device plus a rule-level reference
// model, driven by directed scenarios and a randomized request stream.
module tb_dm_port_arbiter;

    localparam int unsigned STREAK_MAX = 4;

    logic        clk;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    dm_port_arbiter #(
        .STREAK_MAX (STREAK_MAX)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F96;
    endfunction

    // RAM device driven by the DUT's RAM port.
    logic [31:0] dev_mem [logic [29:0]];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen == 4'b0000) begin
                ram_rdata <= dev_mem.exists(ram_addr[31:2]) ? dev_mem[ram_addr[31:2]]
                                                             : init_word(ram_addr);
            end else begin
                logic [31:0] w;
                w = dev_mem.exists(ram_addr[31:2]) ? dev_mem[ram_addr[31:2]]
                                                    : init_word(ram_addr);
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
                end
                dev_mem[ram_addr[31:2]] = w;
            end
        end
    end

    // Reference model: memory image, IF wait count, pending response, hold values.
    logic [31:0] ref_mem [logic [29:0]];
    int          m_streak;
    int          m_prev;      // 0 none, 1 IF, 2 MEM response due this cycle
    logic [31:0] m_prev_data;
    logic [31:0] m_if_hold;
    logic [31:0] m_mem_hold;
    logic        last_ig;
    logic        last_mg;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        ref_mem[a[31:2]] = w;
    endtask

    task automatic model_reset();
        m_streak   = 0;
        m_prev     = 0;
        m_if_hold  = '0;
        m_mem_hold = '0;
    endtask

    // One clock cycle: drive at edge+1, check at edge+4, advance model at the edge.
    task automatic step(input logic ir, input logic [31:0] ia, input logic mr,
                        input logic [3:0] mw, input logic [31:0] ma, input logic [31:0] md);
        logic eig, emg;
        if_req = ir; if_addr = ia;
        mem_req = mr; mem_wen = mw; mem_addr = ma; mem_wdata = md;
        #3;
        emg = mr && !(ir && m_streak == STREAK_MAX);
        eig = ir && !emg;
        last_ig = if_gnt;
        last_mg = mem_gnt;
        check("if_gnt", 32'(if_gnt), 32'(eig));
        check("mem_gnt", 32'(mem_gnt), 32'(emg));
        check("ram_en", 32'(ram_en), 32'(emg | eig));
        check("ram_wen", 32'(ram_wen), emg ? 32'(mw) : 32'd0);
        check("ram_addr", ram_addr, emg ? ma : (eig ? ia : 32'd0));
        check("ram_wdata", ram_wdata, emg ? md : 32'd0);
        if (m_prev == 1) m_if_hold = m_prev_data;
        if (m_prev == 2) m_mem_hold = m_prev_data;
        check("if_rvalid", 32'(if_rvalid), 32'(m_prev == 1));
        check("mem_rvalid", 32'(mem_rvalid), 32'(m_prev == 2));
        check("if_rdata", if_rdata, m_if_hold);
        check("mem_rdata", mem_rdata, m_mem_hold);
        if (emg && ir) m_streak = (m_streak < STREAK_MAX) ? m_streak + 1 : STREAK_MAX;
        else if (eig || !ir) m_streak = 0;
        m_prev = (emg && mw == 4'b0000) ? 2 : (eig ? 1 : 0);
        m_prev_data = ref_read(emg ? ma : ia);
        if (emg && mw != 4'b0000) ref_write(ma, mw, md);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {30'd0, if_gnt, mem_gnt}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, if_rvalid, mem_rvalid}, 32'd0);
        check({tag, "_ram_en_wen"}, {27'd0, ram_en, ram_wen}, 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    endtask

    logic        r_ir, r_mr;
    logic [31:0] r_ia, r_ma, r_md;
    logic [3:0]  r_mw;

    initial begin
        resetn = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0;
        model_reset();
        last_ig = 1'b0; last_mg = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);

        // IF only: three back-to-back fetches of 0x100, then idle with data held.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100, 1'b0, 4'd0, 32'd0, 32'd0);
        check("if_only_rvalid", 32'(if_rvalid), 32'd1);
        check("if_only_rdata", if_rdata, init_word(32'h100));
        idle(3);
        check("if_only_hold", if_rdata, init_word(32'h100));

        // MEM half-word store then readback.
        step(1'b0, 32'd0, 1'b1, 4'b0011, 32'h204, 32'h0000_BEEF);
        check("store_no_rvalid", 32'(mem_rvalid), 32'd0);
        step(1'b0, 32'd0, 1'b1, 4'b0000, 32'h204, 32'd0);
        step(1'b0, 32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
        check("store_readback", {16'd0, mem_rdata[15:0]}, 32'h0000_BEEF);

        // Contention: M,M,M,M,I repeating.
        idle(1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h40 + 32'(i * 4), 1'b1, 4'd0, 32'h300 + 32'(i * 4), 32'd0);
            check("contention_pattern", {30'd0, last_ig, last_mg},
                  (i % 5 == 4) ? 32'd2 : 32'd1);
        end
        idle(2);

        // Interleaved: MEM read 0x300 then IF read 0x40.
        step(1'b0, 32'd0, 1'b1, 4'd0, 32'h300, 32'd0);
        step(1'b1, 32'h40, 1'b0, 4'd0, 32'd0, 32'd0);
        check("interleave_mem_data", mem_rdata, init_word(32'h300));
        step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        check("interleave_if_data", if_rdata, init_word(32'h40));
        check("interleave_mem_kept", mem_rdata, init_word(32'h300));

        // Reset asserted while an IF read response is pending.
        step(1'b1, 32'h80, 1'b0, 4'd0, 32'd0, 32'd0);
        resetn = 1'b0;
        #2;
        check_all_zero("midread");
        if_req = 1'b0;
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(3);

        // Randomized traffic; requests persist until granted, occasionally withdrawn.
        r_ir = 1'b0; r_mr = 1'b0; r_ia = '0; r_ma = '0; r_md = '0; r_mw = '0;
        for (int c = 0; c < 400; c++) begin
            if (!r_ir || $urandom_range(0, 9) == 0) begin
                r_ir = ($urandom_range(0, 3) != 0);
                r_ia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!r_mr || $urandom_range(0, 9) == 0) begin
                r_mr = ($urandom_range(0, 2) != 0);
                r_ma = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                r_mw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                r_md = $urandom;
            end
            step(r_ir, r_ia, r_mr, r_mw, r_ma, r_md);
            if (last_ig) r_ir = 1'b0;
            if (last_mg) r_mr = 1'b0;
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
